// File: rtl/seq_divider.sv
// Multi-cycle signed restoring divider for the Mini SRC DIV instruction.
// It produces one quotient bit per clock; quotient goes to LO and remainder to HI.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        SIGN,
        DONE
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [WIDTH-1:0] quo_reg;    // dividend magnitude shifting out, quotient bits shifting in
    logic [WIDTH-1:0] rem_reg;    // partial remainder
    logic [WIDTH-1:0] den_mag;    // divisor magnitude
    logic [CW-1:0]    count;
    logic             sign_num;
    logic             sign_den;

    logic             start_ok;
    logic             den_zero;
    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;

    assign start_ok = start && ((state == IDLE) || (state == DONE));
    assign den_zero = (divisor == '0);

    assign busy = (state == CALC) || (state == SIGN);
    assign done = (state == DONE);

    // The most-negative value negates to itself, which read unsigned is exactly 2^(WIDTH-1).
    assign dividend_mag = dividend[WIDTH-1] ? -dividend : dividend;
    assign divisor_mag  = divisor[WIDTH-1]  ? -divisor  : divisor;

    // One restoring step: the extra top bit of the trial difference is the borrow.
    always_comb begin
        // NOTE: every signal written here gets a value on every path, so no latch is inferred.
        rem_shift = {rem_reg, quo_reg[WIDTH-1]};
        trial     = rem_shift - {1'b0, den_mag};
        quo_step  = {quo_reg[WIDTH-2:0], ~trial[WIDTH]};
        rem_step  = trial[WIDTH] ? rem_shift[WIDTH-1:0] : trial[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments so all flops update together.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (start_ok) state_next = den_zero ? DONE : CALC;
                else          state_next = IDLE;
            end
            CALC:    if (count == LAST) state_next = SIGN;
            SIGN:    state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            quo_reg     <= '0;
            rem_reg     <= '0;
            den_mag     <= '0;
            count       <= '0;
            sign_num    <= 1'b0;
            sign_den    <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_ok) begin
                        if (den_zero) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            quo_reg  <= dividend_mag;
                            den_mag  <= divisor_mag;
                            rem_reg  <= '0;
                            count    <= '0;
                            sign_num <= dividend[WIDTH-1];
                            sign_den <= divisor[WIDTH-1];
                        end
                    end
                end
                CALC: begin
                    quo_reg <= quo_step;
                    rem_reg <= rem_step;
                    count   <= count + 1'b1;
                end
                SIGN: begin
                    // Truncation toward zero: the remainder follows the dividend's sign.
                    quotient    <= (sign_num ^ sign_den) ? -quo_reg : quo_reg;
                    remainder   <= sign_num ? -rem_reg : rem_reg;
                    div_by_zero <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider at WIDTH=32: latency, signs, overflow,
// divide-by-zero, ignored restart, back-to-back and mid-operation reset.
module tb_seq_divider;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge: this cycle is cycle 0 (start high).
    // Returns at the falling edge of the done cycle with start low.
    task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp_q, input logic [W-1:0] exp_r,
                           input logic exp_dz, input int poke_cycle);
        int  exp_done;
        int  c;
        int  busy_bad;
        bit  seen;
        exp_done = (b == '0) ? 1 : W + 2;
        busy_bad = 0;
        seen     = 1'b0;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        for (c = 1; c <= 100; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy !== ((c < exp_done) && (b != '0))) busy_bad++;
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (c == poke_cycle) begin
                start    = 1'b1;
                dividend = 32'd50;
                divisor  = 32'd5;
            end
        end
        check({tag, " done_seen"}, 64'(seen), 64'd1);
        check({tag, " done_cycle"}, 64'(c), 64'(exp_done));
        check({tag, " busy_window"}, 64'(busy_bad), 64'd0);
        check({tag, " quotient"}, 64'(quotient), 64'(exp_q));
        check({tag, " remainder"}, 64'(remainder), 64'(exp_r));
        check({tag, " div_by_zero"}, 64'(div_by_zero), 64'(exp_dz));
    endtask

    // One idle cycle after a done; done must already have dropped.
    task automatic idle_cycle(input string tag);
        @(negedge clk);
        check({tag, " done_width"}, 64'(done), 64'd0);
        check({tag, " idle_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst quotient", 64'(quotient), 64'd0);
        check("rst remainder", 64'(remainder), 64'd0);
        check("rst div_by_zero", 64'(div_by_zero), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_div("pp", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 0);
        idle_cycle("pp");
        run_div("np", -32'sd100, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 0);
        idle_cycle("np");
        run_div("pn", 32'd100, -32'sd7, 32'hFFFF_FFF2, 32'd2, 1'b0, 0);
        idle_cycle("pn");
        run_div("nn", -32'sd100, -32'sd7, 32'd14, 32'hFFFF_FFFE, 1'b0, 0);
        idle_cycle("nn");
        run_div("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 0);
        idle_cycle("ovf");
        run_div("min_by_1", 32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, 1'b0, 0);
        idle_cycle("min_by_1");
        run_div("min_by_min", 32'h8000_0000, 32'h8000_0000, 32'd1, 32'd0, 1'b0, 0);
        idle_cycle("min_by_min");
        run_div("max_by_min", 32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 32'h7FFF_FFFF, 1'b0, 0);
        idle_cycle("max_by_min");
        run_div("small", 32'd7, 32'd100, 32'd0, 32'd7, 1'b0, 0);
        idle_cycle("small");
        run_div("dz_pos", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 0);
        idle_cycle("dz_pos");
        check("dz_hold", 64'(div_by_zero), 64'd1);
        run_div("after_dz", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 0);
        idle_cycle("after_dz");
        run_div("dz_neg", -32'sd7, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1, 0);
        idle_cycle("dz_neg");

        // Restart attempt at cycle 5 must be ignored, then a back-to-back start in the done cycle.
        run_div("ignore", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 5);
        run_div("b2b", 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 0);
        idle_cycle("b2b");
        check("hold quotient", 64'(quotient), 64'd10);

        // Reset in cycle 10 of a division aborts it.
        dones    = 0;
        start    = 1'b1;
        dividend = 32'd100;
        divisor  = 32'd7;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c >= 11 && done === 1'b1) dones++;
            if (c == 10) rst = 1'b1;
            if (c == 11) begin
                rst = 1'b0;
                check("abort busy", 64'(busy), 64'd0);
                check("abort quotient", 64'(quotient), 64'd0);
                check("abort remainder", 64'(remainder), 64'd0);
                check("abort div_by_zero", 64'(div_by_zero), 64'd0);
            end
        end
        check("abort no_done", 64'(dones), 64'd0);

        run_div("recover", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
